spi_master: RTL and testbench

- Single-clock SPI mode-0 initiator for the NPU control link. It drives the host side of the 24-bit command frame protocol.
- Serialises a 24-bit frame MSB-first on mosi while generating sclk and cs_n from the system clock.
- Captures the 8-bit response byte returned on miso during frame bits 7..14.
- Used by on-chip test/bring-up logic and loopback benches to drive the SPI slave port of the accelerator.

---
 rtl/spi_master.sv | 161 ++++++++++++++++
 tb/tb_spi_master.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 initiator for the 24-bit NPU command frame.
// Shifts tx_frame out MSB-first and captures the response byte from frame bits 7..14.
`default_nettype none

module spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] tx_frame,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rx_data,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  input  logic        miso
);

  localparam int MAX_A  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B  = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] LAST_DIV   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LAST_SETUP = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] LAST_HOLD  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] LAST_GAP   = CW'(CS_GAP - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    XFER_LO = 3'd2,
    XFER_HI = 3'd3,
    HOLD    = 3'd4,
    GAP     = 3'd5
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [4:0]    bit_idx, bit_nx;
  logic [22:0]   tx_sh, tx_sh_nx;
  logic [7:0]    rx_sh, rx_sh_nx, rx_data_nx;
  logic          busy_nx, done_nx, sclk_nx, mosi_nx, cs_n_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_nx;
      tx_sh   <= tx_sh_nx;
      rx_sh   <= rx_sh_nx;
      rx_data <= rx_data_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      sclk    <= sclk_nx;
      mosi    <= mosi_nx;
      cs_n    <= cs_n_nx;
    end
  end

  // Outputs are computed one cycle ahead so every pin leaves a flop.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + 1'b1;
    bit_nx     = bit_idx;
    tx_sh_nx   = tx_sh;
    rx_sh_nx   = rx_sh;
    rx_data_nx = rx_data;
    busy_nx    = busy;
    done_nx    = 1'b0;
    sclk_nx    = sclk;
    mosi_nx    = mosi;
    cs_n_nx    = cs_n;

    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (start) begin
          state_nx = SETUP;
          bit_nx   = '0;
          tx_sh_nx = tx_frame[22:0];
          rx_sh_nx = '0;
          cs_n_nx  = 1'b0;
          mosi_nx  = tx_frame[23];
          busy_nx  = 1'b1;
        end
      end
      SETUP: begin
        if (cnt == LAST_SETUP) begin
          state_nx = XFER_LO;
          cnt_nx   = '0;
        end
      end
      XFER_LO: begin
        if (cnt == LAST_DIV) begin
          state_nx = XFER_HI;
          cnt_nx   = '0;
          sclk_nx  = 1'b1;
        end
      end
      XFER_HI: begin
        if (cnt == LAST_DIV) begin
          cnt_nx  = '0;
          sclk_nx = 1'b0;
          if (bit_idx >= 5'd7 && bit_idx <= 5'd14) begin
            rx_sh_nx = {rx_sh[6:0], miso};
          end
          if (bit_idx == 5'd23) begin
            state_nx = HOLD;
          end else begin
            state_nx = XFER_LO;
            bit_nx   = bit_idx + 5'd1;
            mosi_nx  = tx_sh[22];
            tx_sh_nx = {tx_sh[21:0], 1'b0};
          end
        end
      end
      HOLD: begin
        if (cnt == LAST_HOLD) begin
          state_nx   = GAP;
          cnt_nx     = '0;
          cs_n_nx    = 1'b1;
          mosi_nx    = 1'b0;
          rx_data_nx = rx_sh;
          done_nx    = 1'b1;
        end
      end
      GAP: begin
        if (cnt == LAST_GAP) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          busy_nx  = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized scoreboard bench for spi_master with a frame-level
// timing model and a miso responder that returns a per-frame response byte.
`default_nettype none

module tb_spi_master;

  localparam int D        = 2;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_GAP   = 8;
  localparam int FRAME    = CS_SETUP + 48 * D + CS_HOLD;

  logic        clk = 1'b0;
  logic        rst_n, start, miso;
  logic [23:0] tx_frame;
  logic        busy, done, sclk, mosi, cs_n;
  logic [7:0]  rx_data;

  spi_master #(.CLK_DIV(D), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_frame(tx_frame),
    .busy(busy), .done(done), .rx_data(rx_data),
    .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] frame;
    logic [7:0]  resp;
    int          t0;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          free_at = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  resp = 8'h00;
  logic [7:0]  cur_resp = 8'h00;
  logic [7:0]  exp_rx = 8'h00;
  logic [23:0] cap = 24'h0;
  int          edges = 0;
  logic        prev_sclk = 1'b0;
  logic        sl_prev = 1'b0;
  int          sl_edges = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: frame acceptance and busy window in absolute cycle numbers.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      exp_rx  = 8'h00;
      free_at = cyc + 1;
    end else if (start && cyc >= free_at) begin
      q.push_back('{frame: tx_frame, resp: resp, t0: cyc});
      cur_resp = resp;
      free_at  = cyc + FRAME + CS_GAP + 1;
    end
  end

  // Slave responder: response byte on rising edges 8..15, noise elsewhere.
  always @(negedge clk) begin
    if (cs_n !== 1'b0) begin
      sl_edges = 0;
      miso     = 1'b0;
    end else if (sclk && !sl_prev) begin
      sl_edges++;
      if (sl_edges >= 8 && sl_edges <= 15) miso = cur_resp[15 - sl_edges];
      else                                 miso = 1'($urandom_range(0, 1));
    end
    sl_prev = sclk;
  end

  // Monitor: per-cycle waveform check and scoreboard pop on done.
  always @(negedge clk) begin : mon
    logic e_cs, e_sclk, e_mosi, e_done;
    int   k, b;
    exp_t e;
    if (cyc > 0) begin
      if (q.size() > 0 && cyc > q[0].t0 + FRAME) begin
        n_vec++;
        n_err++;
        $display("FAIL done_timeout: got no done expected done at cycle %0d", q[0].t0 + FRAME);
        void'(q.pop_front());
      end
      e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_done = 1'b0;
      if (q.size() > 0) begin
        e = q[0];
        if (cyc == e.t0 + FRAME) begin
          e_done = 1'b1;
        end else begin
          e_cs = 1'b0;
          k = cyc - e.t0 - CS_SETUP;
          if (k < 0) begin
            e_mosi = e.frame[23];
          end else if (k < 48 * D) begin
            b      = k / (2 * D);
            e_sclk = (k % (2 * D)) >= D;
            e_mosi = e.frame[23 - b];
          end else begin
            e_mosi = e.frame[0];
          end
        end
      end
      chk("cs_n", 32'(cs_n), 32'(e_cs));
      chk("sclk", 32'(sclk), 32'(e_sclk));
      chk("mosi", 32'(mosi), 32'(e_mosi));
      chk("done", 32'(done), 32'(e_done));
      chk("busy", 32'(busy), 32'(cyc < free_at - 1));

      if (sclk === 1'b1 && prev_sclk === 1'b0) begin
        cap = {cap[22:0], mosi};
        edges++;
      end
      prev_sclk = sclk;

      if (done === 1'b1) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done expected none at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.t0 + FRAME));
          chk("mosi_frame", 32'(cap), 32'(e.frame));
          chk("rise_edges", 32'(edges), 32'd24);
          chk("rx_data", 32'(rx_data), 32'(e.resp));
          exp_rx = e.resp;
        end
        cap = '0;
        edges = 0;
      end else begin
        chk("rx_hold", 32'(rx_data), 32'(exp_rx));
        if (q.size() == 0) begin
          cap = '0;
          edges = 0;
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc < free_at) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] f, input logic [7:0] r);
    tx_frame = f;
    resp     = r;
    pulse_start();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tx_frame = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Known pattern, then a second frame across which rx_data must hold.
    send(24'hA54C3F, 8'h96);
    wait_idle();
    send(24'h5A0F81, 8'h3C);
    wait_idle();

    // Starts during SETUP, XFER and GAP are ignored.
    send(24'h123456, 8'hE1);
    pulse_start();
    repeat (30) @(posedge clk);
    #1 pulse_start();
    repeat (FRAME - 30) @(posedge clk);
    #1 pulse_start();
    wait_idle();

    // tx_frame changes after acceptance do not reach the wire.
    send(24'hFFFFFF, 8'h00);
    tx_frame = 24'h000000;
    wait_idle();

    // Reset during bit 12 abandons the frame; a clean frame follows.
    send(24'hC3A5F0, 8'h5A);
    repeat (CS_SETUP + 24 * D + 1) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(24'h0F0F0F, 8'hA7);
    wait_idle();

    // start held high: back-to-back frames separated by CS_GAP+1 high cycles.
    start = 1'b1;
    repeat (3 * (FRAME + CS_GAP + 1)) begin
      tx_frame = 24'($urandom);
      resp     = 8'($urandom);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_idle();

    // Randomized frames with stray starts landing anywhere.
    repeat (16) begin
      send(24'($urandom), 8'($urandom));
      repeat ($urandom_range(0, FRAME + CS_GAP + 20)) @(posedge clk);
      #1;
      if ($urandom_range(0, 1) == 1) send(24'($urandom), 8'($urandom));
      wait_idle();
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
